// File: rtl/control_sequencer.sv
// control_sequencer
//    Top-level control FSM of the audio sampler. Converts debounced key and
//    switch levels into one-cycle start/stop commands for the record, play,
//    mix and (optionally) pitch engines. Resolves the chunk selection to an
//    SDRAM base address or a mix mask, tracks the active engine's done
//    handshake and recovers from engines that never finish via a watchdog.
//
//    Build option: define CONTROL_PITCH_EN to enable the PITCH state, KEY[3]
//    and the pitch ports. Without it PITCH is unreachable and o_pitch_* are 0.
//
// Ports
//    i_clk, i_rst_n        clock, asynchronous active-low reset
//    i_key[3:0]            REC, PLAY, STOP, PITCH key levels (active high)
//    i_chunk_sel           one bit per sample chunk
//    i_mix_req             mix request level
//    i_pitch_mode/speed    pitch settings, latched on PITCH entry
//    i_*_done              engine completion pulses
//    o_mode                0 IDLE, 1 REC, 2 PLAY, 3 MIX, 4 PITCH
//    o_*_start, o_*_stop   one-cycle engine commands
//    o_addr                base address of the selected chunk
//    o_mix_mask, o_mix_num chunks in the mix and their count
//    o_pitch_mode/speed    latched pitch settings
//    o_err                 one-cycle error pulse (bad selection or timeout)
module control_sequencer #(
   parameter int                NUM_CHUNKS     = 5,
   parameter int                ADDR_W         = 23,
   parameter logic [ADDR_W-1:0] CHUNK_WORDS    = 23'h100000,
   parameter logic [31:0]       TIMEOUT_CYCLES = 32'd500_000_000
) (
   input  logic                              i_clk,
   input  logic                              i_rst_n,
   input  logic [3:0]                        i_key,
   input  logic [NUM_CHUNKS-1:0]             i_chunk_sel,
   input  logic                              i_mix_req,
   input  logic                              i_pitch_mode,
   input  logic [3:0]                        i_pitch_speed,
   input  logic                              i_rec_done,
   input  logic                              i_play_done,
   input  logic                              i_mix_done,
   input  logic                              i_pitch_done,
   output logic [2:0]                        o_mode,
   output logic                              o_rec_start,
   output logic                              o_play_start,
   output logic                              o_mix_start,
   output logic                              o_pitch_start,
   output logic                              o_rec_stop,
   output logic                              o_play_stop,
   output logic                              o_mix_stop,
   output logic                              o_pitch_stop,
   output logic [ADDR_W-1:0]                 o_addr,
   output logic [NUM_CHUNKS-1:0]             o_mix_mask,
   output logic [$clog2(NUM_CHUNKS+1)-1:0]   o_mix_num,
   output logic                              o_pitch_mode,
   output logic [3:0]                        o_pitch_speed,
   output logic                              o_err
);

   localparam int CNT_W = $clog2(NUM_CHUNKS+1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_REC   = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_MIX   = 3'd3;
   localparam logic [2:0] S_PITCH = 3'd4;

   logic [2:0]            state_reg;
   logic                  armed_reg;
   logic [3:0]            key_q_reg;
   logic [3:0]            key_rise_reg;
   logic                  mix_q_reg;
   logic                  mix_rise_reg;
   logic                  done_reg;
   logic                  stop_issued_reg;
   logic [31:0]           wd_cnt_reg;
   logic [3:0]            start_reg;     // {pitch, mix, play, rec}
   logic [3:0]            stop_reg;
   logic                  err_reg;
   logic [ADDR_W-1:0]     addr_reg;
   logic [NUM_CHUNKS-1:0] mask_reg;
   logic [CNT_W-1:0]      num_reg;

   logic [ADDR_W-1:0]     base_tab [NUM_CHUNKS];
   logic [ADDR_W-1:0]     sel_base;
   logic [CNT_W-1:0]      sel_count;
   logic                  sel_onehot;
   logic                  sel_any;
   logic                  pitch_rise;
   logic                  pitch_done_in;
   logic [3:0]            eng_bit;
   logic                  eng_done;
   logic                  timeout_hit;
   logic [2:0]            enter_state;
   logic [3:0]            enter_bit;
   logic                  enter_err;

   // Chunk base addresses, truncated to the address width.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CHUNKS; gi++) begin : g_base
         assign base_tab[gi] = ADDR_W'(gi) * CHUNK_WORDS;
      end
   endgenerate

   // The OR-mux is only meaningful for one-hot selections, which is the only
   // case in which sel_base is latched.
   always_comb begin
      sel_base  = '0;
      sel_count = '0;
      for (int k = 0; k < NUM_CHUNKS; k++) begin
         if (i_chunk_sel[k]) begin
            sel_base = sel_base | base_tab[k];
         end
         sel_count = sel_count + CNT_W'(i_chunk_sel[k]);
      end
   end

   assign sel_onehot = (sel_count == CNT_W'(1));
   assign sel_any    = |i_chunk_sel;

   // Engine owned by the current state; only its done is honoured.
   always_comb begin
      eng_bit = 4'b0000;
      case (state_reg)
         S_REC:   eng_bit = 4'b0001;
         S_PLAY:  eng_bit = 4'b0010;
         S_MIX:   eng_bit = 4'b0100;
         S_PITCH: eng_bit = 4'b1000;
         default: eng_bit = 4'b0000;
      endcase
   end

   assign eng_done    = |(eng_bit & {pitch_done_in, i_mix_done, i_play_done, i_rec_done});
   assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (wd_cnt_reg == TIMEOUT_CYCLES - 32'd1);

   // IDLE entry decision with fixed priority REC > PLAY > MIX > PITCH.
   always_comb begin
      enter_state = S_IDLE;
      enter_bit   = 4'b0000;
      enter_err   = 1'b0;
      if (state_reg == S_IDLE) begin
         if (key_rise_reg[0]) begin
            if (sel_onehot) begin
               enter_state = S_REC;
               enter_bit   = 4'b0001;
            end else begin
               enter_err = 1'b1;
            end
         end else if (key_rise_reg[1]) begin
            if (sel_onehot) begin
               enter_state = S_PLAY;
               enter_bit   = 4'b0010;
            end else begin
               enter_err = 1'b1;
            end
         end else if (mix_rise_reg) begin
            if (sel_any) begin
               enter_state = S_MIX;
               enter_bit   = 4'b0100;
            end else begin
               enter_err = 1'b1;
            end
         end else if (pitch_rise) begin
            if (sel_onehot) begin
               enter_state = S_PITCH;
               enter_bit   = 4'b1000;
            end else begin
               enter_err = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg       <= S_IDLE;
         armed_reg       <= 1'b0;
         key_q_reg       <= 4'b0000;
         key_rise_reg    <= 4'b0000;
         mix_q_reg       <= 1'b0;
         mix_rise_reg    <= 1'b0;
         done_reg        <= 1'b0;
         stop_issued_reg <= 1'b0;
         wd_cnt_reg      <= 32'd0;
         start_reg       <= 4'b0000;
         stop_reg        <= 4'b0000;
         err_reg         <= 1'b0;
         addr_reg        <= '0;
         mask_reg        <= '0;
         num_reg         <= '0;
      end else begin
         // Edge detection is suppressed for the first cycle after reset so
         // that keys held through reset are taken as the reference level.
         armed_reg    <= 1'b1;
         key_q_reg    <= i_key;
         mix_q_reg    <= i_mix_req;
         key_rise_reg <= armed_reg ? (i_key & ~key_q_reg) : 4'b0000;
         mix_rise_reg <= armed_reg & i_mix_req & ~mix_q_reg;
         // eng_done is zero in IDLE, so a done seen on the entry edge is dropped.
         done_reg     <= eng_done;
         start_reg    <= 4'b0000;
         stop_reg     <= 4'b0000;
         err_reg      <= enter_err;

         if (state_reg == S_IDLE) begin
            stop_issued_reg <= 1'b0;
            wd_cnt_reg      <= 32'd0;
            if (enter_state != S_IDLE) begin
               state_reg <= enter_state;
               start_reg <= enter_bit;
               if (enter_state == S_MIX) begin
                  mask_reg <= i_chunk_sel;
                  num_reg  <= sel_count;
               end else begin
                  addr_reg <= sel_base;
               end
            end
         end else if (done_reg) begin
            // Done beats a coincident STOP edge and the watchdog.
            state_reg <= S_IDLE;
         end else if (timeout_hit) begin
            state_reg <= S_IDLE;
            stop_reg  <= eng_bit;
            err_reg   <= 1'b1;
         end else begin
            wd_cnt_reg <= wd_cnt_reg + 32'd1;
            if (key_rise_reg[2] && !stop_issued_reg) begin
               stop_reg        <= eng_bit;
               stop_issued_reg <= 1'b1;
            end
         end
      end
   end

   assign o_mode       = state_reg;
   assign o_rec_start  = start_reg[0];
   assign o_play_start = start_reg[1];
   assign o_mix_start  = start_reg[2];
   assign o_rec_stop   = stop_reg[0];
   assign o_play_stop  = stop_reg[1];
   assign o_mix_stop   = stop_reg[2];
   assign o_addr       = addr_reg;
   assign o_mix_mask   = mask_reg;
   assign o_mix_num    = num_reg;
   assign o_err        = err_reg;

`ifdef CONTROL_PITCH_EN
   logic       pitch_mode_reg;
   logic [3:0] pitch_speed_reg;

   assign pitch_rise    = key_rise_reg[3];
   assign pitch_done_in = i_pitch_done;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pitch_mode_reg  <= 1'b0;
         pitch_speed_reg <= 4'd0;
      end else if (enter_state == S_PITCH) begin
         pitch_mode_reg  <= i_pitch_mode;
         pitch_speed_reg <= i_pitch_speed;
      end
   end

   assign o_pitch_start = start_reg[3];
   assign o_pitch_stop  = stop_reg[3];
   assign o_pitch_mode  = pitch_mode_reg;
   assign o_pitch_speed = pitch_speed_reg;
`else
   logic pitch_unused;

   assign pitch_rise    = 1'b0;
   assign pitch_done_in = 1'b0;
   // Pitch inputs and bookkeeping bits have no function in this build.
   assign pitch_unused  = ^{key_rise_reg[3], start_reg[3], stop_reg[3],
                            i_pitch_mode, i_pitch_speed, i_pitch_done};

   assign o_pitch_start = 1'b0;
   assign o_pitch_stop  = 1'b0;
   assign o_pitch_mode  = 1'b0;
   assign o_pitch_speed = 4'd0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//    Directed and randomized stimulus for control_sequencer. A transaction
//    model derives the expected mode, error, start/stop pulses and latched
//    values from the key/selection rules and checks them at fixed cycles.
module tb_control_sequencer;

   localparam int              NC  = 5;
   localparam int              AW  = 23;
   localparam logic [AW-1:0]   CW  = 23'h100000;
   localparam int              TMO = 16;
`ifdef CONTROL_PITCH_EN
   localparam bit PITCH_EN = 1'b1;
`else
   localparam bit PITCH_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [3:0]    i_key;
   logic [NC-1:0] i_chunk_sel;
   logic          i_mix_req;
   logic          i_pitch_mode;
   logic [3:0]    i_pitch_speed;
   logic          i_rec_done, i_play_done, i_mix_done, i_pitch_done;
   logic [2:0]    o_mode;
   logic          o_rec_start, o_play_start, o_mix_start, o_pitch_start;
   logic          o_rec_stop, o_play_stop, o_mix_stop, o_pitch_stop;
   logic [AW-1:0] o_addr;
   logic [NC-1:0] o_mix_mask;
   logic [2:0]    o_mix_num;
   logic          o_pitch_mode;
   logic [3:0]    o_pitch_speed;
   logic          o_err;

   control_sequencer #(
      .NUM_CHUNKS(NC), .ADDR_W(AW), .CHUNK_WORDS(CW), .TIMEOUT_CYCLES(32'(TMO))
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_key(i_key), .i_chunk_sel(i_chunk_sel),
      .i_mix_req(i_mix_req), .i_pitch_mode(i_pitch_mode), .i_pitch_speed(i_pitch_speed),
      .i_rec_done(i_rec_done), .i_play_done(i_play_done), .i_mix_done(i_mix_done),
      .i_pitch_done(i_pitch_done), .o_mode(o_mode),
      .o_rec_start(o_rec_start), .o_play_start(o_play_start),
      .o_mix_start(o_mix_start), .o_pitch_start(o_pitch_start),
      .o_rec_stop(o_rec_stop), .o_play_stop(o_play_stop),
      .o_mix_stop(o_mix_stop), .o_pitch_stop(o_pitch_stop),
      .o_addr(o_addr), .o_mix_mask(o_mix_mask), .o_mix_num(o_mix_num),
      .o_pitch_mode(o_pitch_mode), .o_pitch_speed(o_pitch_speed), .o_err(o_err)
   );

   always #5 clk = ~clk;

   wire [3:0] starts = {o_pitch_start, o_mix_start, o_play_start, o_rec_start};
   wire [3:0] stops  = {o_pitch_stop, o_mix_stop, o_play_stop, o_rec_stop};

   int checks = 0;
   int errors = 0;

   // Reference model state: current mode and the values latched on entry.
   int            cur_mode = 0;
   logic [AW-1:0] m_addr   = '0;
   logic [NC-1:0] m_mask   = '0;
   int            m_num    = 0;
   logic          m_pmode  = 1'b0;
   logic [3:0]    m_pspeed = 4'd0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] eng(input int mode);
      return (mode == 0) ? 4'b0000 : 4'(1 << (mode - 1));
   endfunction

   task automatic set_dones(input logic [3:0] v);
      {i_pitch_done, i_mix_done, i_play_done, i_rec_done} = v;
   endtask

   task automatic chk_latched(input string tag);
      chk({tag, "_addr"},   o_addr, m_addr);
      chk({tag, "_mask"},   o_mix_mask, m_mask);
      chk({tag, "_num"},    o_mix_num, 64'(m_num));
      chk({tag, "_pmode"},  o_pitch_mode, m_pmode);
      chk({tag, "_pspeed"}, o_pitch_speed, m_pspeed);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mode"},   o_mode, 0);
      chk({tag, "_starts"}, starts, 0);
      chk({tag, "_stops"},  stops, 0);
      chk({tag, "_err"},    o_err, 0);
      chk({tag, "_addr"},   o_addr, 0);
      chk({tag, "_mask"},   o_mix_mask, 0);
      chk({tag, "_num"},    o_mix_num, 0);
      chk({tag, "_pmode"},  o_pitch_mode, 0);
      chk({tag, "_pspeed"}, o_pitch_speed, 0);
   endtask

   // Apply key/mix edges with a selection and check the entry outcome.
   task automatic try_enter(input logic [3:0] key, input logic mix, input logic [NC-1:0] sel);
      int  cand;
      int  exp_mode;
      bit  exp_err;
      int  idx;
      cand = 0;
      if (key[0])                    cand = 1;
      else if (key[1])               cand = 2;
      else if (mix)                  cand = 3;
      else if (key[3] && PITCH_EN)   cand = 4;
      exp_mode = 0;
      exp_err  = 1'b0;
      if (cand == 3) begin
         if (sel != '0) exp_mode = 3; else exp_err = 1'b1;
      end else if (cand != 0) begin
         if ($countones(sel) == 1) exp_mode = cand; else exp_err = 1'b1;
      end
      i_chunk_sel   = sel;
      i_key         = key;
      i_mix_req     = mix;
      i_pitch_mode  = 1'($urandom);
      i_pitch_speed = 4'($urandom);
      tick();
      chk("pre_mode", o_mode, 0);
      chk("pre_start", starts, 0);
      chk("pre_err", o_err, 0);
      tick();
      if (exp_mode == 3) begin
         m_mask = sel;
         m_num  = $countones(sel);
      end else if (exp_mode != 0) begin
         idx = 0;
         for (int k = 0; k < NC; k++) if (sel[k]) idx = k;
         m_addr = AW'(longint'(idx) * longint'(CW));
         if (exp_mode == 4) begin
            m_pmode  = i_pitch_mode;
            m_pspeed = i_pitch_speed;
         end
      end
      chk("enter_mode", o_mode, 64'(exp_mode));
      chk("enter_start", starts, eng(exp_mode));
      chk("enter_err", o_err, 64'(exp_err));
      chk_latched("enter");
      i_key         = 4'b0000;
      i_mix_req     = 1'b0;
      i_chunk_sel   = NC'($urandom);
      i_pitch_mode  = 1'($urandom);
      i_pitch_speed = 4'($urandom);
      tick();
      chk("start_once", starts, 0);
      chk("err_once", o_err, 0);
      chk("hold_mode", o_mode, 64'(exp_mode));
      chk_latched("hold");
      cur_mode = exp_mode;
      $display("enter key=%b mix=%b sel=%b -> mode=%0d err=%0d", key, mix, sel, exp_mode, exp_err);
   endtask

   task automatic do_done();
      set_dones(eng(cur_mode) | 4'($urandom));
      tick();
      set_dones(4'b0000);
      chk("done_wait_mode", o_mode, 64'(cur_mode));
      tick();
      chk("done_mode", o_mode, 0);
      chk("done_stops", stops, 0);
      chk("done_err", o_err, 0);
      $display("done mode=%0d", cur_mode);
      cur_mode = 0;
   endtask

   task automatic do_stop_then_done();
      i_key[2] = 1'b1;
      tick();
      tick();
      chk("stop_pulse", stops, eng(cur_mode));
      tick();
      chk("stop_once", stops, 0);
      chk("stop_mode", o_mode, 64'(cur_mode));
      i_key[2] = 1'b0;
      tick();
      i_key[2] = 1'b1;
      tick();
      tick();
      chk("stop_again_ignored", stops, 0);
      i_key[2] = 1'b0;
      $display("stop mode=%0d", cur_mode);
      do_done();
   endtask

   task automatic do_wrong_done();
      set_dones(~eng(cur_mode));
      tick();
      set_dones(4'b0000);
      tick();
      chk("wrong_done_mode", o_mode, 64'(cur_mode));
      tick();
      chk("wrong_done_mode2", o_mode, 64'(cur_mode));
      do_done();
   endtask

   task automatic do_stop_and_done();
      i_key[2] = 1'b1;
      set_dones(eng(cur_mode));
      tick();
      i_key[2] = 1'b0;
      set_dones(4'b0000);
      tick();
      chk("sd_mode", o_mode, 0);
      chk("sd_stops", stops, 0);
      $display("stop+done mode=%0d", cur_mode);
      cur_mode = 0;
   endtask

   // Called one edge after the start edge; timeout fires TMO edges after it.
   task automatic do_timeout();
      repeat (TMO - 2) tick();
      chk("tmo_early_mode", o_mode, 64'(cur_mode));
      chk("tmo_early_stops", stops, 0);
      tick();
      chk("tmo_stops", stops, eng(cur_mode));
      chk("tmo_err", o_err, 1);
      chk("tmo_mode", o_mode, 0);
      tick();
      chk("tmo_stops_once", stops, 0);
      chk("tmo_err_once", o_err, 0);
      $display("timeout mode=%0d", cur_mode);
      cur_mode = 0;
   endtask

   task automatic idle_poke();
      i_key[2] = 1'b1;
      set_dones(4'($urandom));
      tick();
      i_key[2] = 1'b0;
      set_dones(4'b0000);
      tick();
      chk("idle_mode", o_mode, 0);
      chk("idle_stops", stops, 0);
      chk("idle_starts", starts, 0);
      chk("idle_err", o_err, 0);
      tick();
   endtask

   task automatic finish_op(input int kind);
      case (kind)
         0: do_done();
         1: do_stop_then_done();
         2: do_wrong_done();
         3: do_stop_and_done();
         default: do_timeout();
      endcase
   endtask

   initial begin
      logic [3:0]    key;
      logic          mix;
      logic [NC-1:0] sel;
      rst_n = 1'b0;
      i_key = 4'b0000;
      i_chunk_sel = '0;
      i_mix_req = 1'b0;
      i_pitch_mode = 1'b0;
      i_pitch_speed = 4'd0;
      set_dones(4'b0000);
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();
      tick();
      chk_all_zero("post_reset");

      // Single REC on chunk 2.
      try_enter(4'b0001, 1'b0, 5'b00100);
      chk("rec_addr_const", o_addr, 23'h200000);
      do_done();

      // Mix of three chunks, then STOP.
      try_enter(4'b0000, 1'b1, 5'b01011);
      chk("mix_num_const", o_mix_num, 3);
      do_stop_then_done();

      // PLAY with a non-one-hot selection is rejected.
      try_enter(4'b0010, 1'b0, 5'b00110);

      // REC beats PLAY.
      try_enter(4'b0011, 1'b0, 5'b00001);
      chk("prio_addr_const", o_addr, 0);
      do_done();

      // MIX with empty selection is rejected.
      try_enter(4'b0000, 1'b1, 5'b00000);

      // PLAY with no done hits the watchdog.
      try_enter(4'b0010, 1'b0, 5'b00010);
      do_timeout();

      // KEY[3] alone: PITCH only in the pitch-enabled build.
      try_enter(4'b1000, 1'b0, 5'b10000);
      if (cur_mode != 0) do_done(); else idle_poke();

      // Reset in the middle of MIX, with keys held through reset.
      try_enter(4'b0000, 1'b1, 5'b11000);
      i_key     = 4'b1011;
      i_mix_req = 1'b1;
      tick();
      rst_n = 1'b0;
      #1;
      cur_mode = 0;
      m_addr = '0; m_mask = '0; m_num = 0; m_pmode = 1'b0; m_pspeed = 4'd0;
      chk_all_zero("async_reset");
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      tick();
      chk("held_keys_mode", o_mode, 0);
      chk("held_keys_starts", starts, 0);
      chk("held_keys_err", o_err, 0);
      i_key     = 4'b0000;
      i_mix_req = 1'b0;
      tick();
      $display("reset during mix");

      // Randomized transactions.
      for (int n = 0; n < 40; n++) begin
         key = 4'b0000;
         key[0] = ($urandom_range(0, 3) == 0);
         key[1] = ($urandom_range(0, 3) == 0);
         key[3] = ($urandom_range(0, 3) == 0);
         mix    = ($urandom_range(0, 3) == 0);
         if (key == 4'b0000 && !mix) key[$urandom_range(0, 1)] = 1'b1;
         if ($urandom_range(0, 2) != 0) sel = NC'(1 << $urandom_range(0, NC - 1));
         else                           sel = NC'($urandom);
         try_enter(key, mix, sel);
         if (cur_mode != 0) finish_op(int'($urandom_range(0, 4)));
         else idle_poke();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised top-level control FSM of the audio sampler. Turns debounced key and switch inputs into one-cycle start/stop commands for the record, play, mix and (optionally) pitch engines. Resolves chunk selections to SDRAM base addresses and tracks each engine's done handshake. A watchdog recovers from engines that never report done.

## Interface
- NUM_CHUNKS, 5: number of sample chunks; selection is one bit per chunk
- ADDR_W, 23: SDRAM word-address width
- CHUNK_WORDS, 23'h100000: words per chunk; base(k) = k*CHUNK_WORDS, truncated to ADDR_W
- TIMEOUT_CYCLES, 32'd500_000_000: cycles an active state may wait for done; 0 disables the watchdog
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_key  in  4  debounced, active-high levels: [0] REC, [1] PLAY, [2] STOP, [3] PITCH
- i_chunk_sel  in  NUM_CHUNKS  chunk selection switches
- i_mix_req  in  1  mix request switch, level
- i_pitch_mode  in  1  0 slow, 1 fast
- i_pitch_speed  in  4  speed factor
- i_rec_done, i_play_done, i_mix_done, i_pitch_done  in  1  engine completion pulses
- o_mode  out  3  0 IDLE, 1 REC, 2 PLAY, 3 MIX, 4 PITCH
- o_rec_start, o_play_start, o_mix_start, o_pitch_start  out  1  one-cycle start pulses
- o_rec_stop, o_play_stop, o_mix_stop, o_pitch_stop  out  1  one-cycle stop pulses
- o_addr  out  ADDR_W  base address of the selected chunk (REC/PLAY/PITCH)
- o_mix_mask  out  NUM_CHUNKS  chunks taking part in the mix
- o_mix_num  out  $clog2(NUM_CHUNKS+1)  popcount of o_mix_mask
- o_pitch_mode  out  1, o_pitch_speed  out  4  latched pitch settings
- o_err  out  1  one-cycle error pulse

## Operation
- Rising edges are detected on i_key and i_mix_req against a registered copy. Levels held high never retrigger.
- IDLE entry priority when edges coincide: REC > PLAY > MIX > PITCH.
- REC, PLAY and PITCH require i_chunk_sel to be exactly one-hot. Otherwise the FSM stays in IDLE and o_err pulses.
- MIX requires a nonzero i_chunk_sel. Otherwise the FSM stays in IDLE and o_err pulses.
- On entry, the FSM latches o_addr = base(index), or o_mix_mask/o_mix_num, or o_pitch_mode/o_pitch_speed, and pulses the matching start. Latched values hold until the next entry; switch changes mid-operation are ignored.
- In an active state, a STOP edge pulses the matching stop once. The FSM then keeps waiting for done; further STOP edges are ignored.
- Only the active engine's done is honoured; other done inputs are ignored. Done returns the FSM to IDLE.
- The watchdog counts cycles in the active state. At TIMEOUT_CYCLES it pulses stop and o_err together and returns to IDLE.
- In IDLE, STOP edges and done inputs are ignored.

## Timing
- All outputs are registered.
- Reset values: o_mode=0; every start, stop and o_err = 0; o_addr=0; o_mix_mask=0; o_mix_num=0; o_pitch_mode=0; o_pitch_speed=0; edge registers=0.
- Key high first sampled at edge N: o_mode and start update at edge N+1, and start stays high for exactly one cycle.
- Done is honoured from the cycle after start. Done sampled at edge M gives o_mode=0 at edge M+1.
- STOP and done sampled at the same edge: stop is not issued, and the FSM returns to IDLE.
- Asserting reset mid-operation clears all outputs immediately, with no stop pulse. Edge detection restarts clean, so keys held through reset do not trigger.

## Configuration
- CONTROL_PITCH_EN defined: PITCH state, KEY[3] and the pitch ports are functional.
- CONTROL_PITCH_EN undefined: PITCH is unreachable, KEY[3] is ignored, and o_pitch_* are tied to 0. i_pitch_* inputs are unused.

## Test plan
- i_chunk_sel=5'b00100, REC edge → o_mode=1, o_addr=23'h200000, o_rec_start one cycle; i_rec_done → o_mode=0 one cycle later.
- i_chunk_sel=5'b01011, i_mix_req rising → o_mix_mask=5'b01011, o_mix_num=3, o_mix_start one cycle; STOP edge → single o_mix_stop.
- i_chunk_sel=5'b00110, PLAY edge → o_err pulse, o_mode stays 0, no start.
- REC and PLAY edges in the same cycle with sel=5'b00001 → REC entered, o_addr=0, no o_play_start.
- TIMEOUT_CYCLES=16, PLAY with no done → on the 16th cycle o_play_stop and o_err pulse together, then o_mode=0.
- Reset asserted during MIX → outputs cleared at once; KEY[3] edge with CONTROL_PITCH_EN undefined → o_mode stays 0.
